// File: rtl/ovi_issue_arbiter.sv
// ovi_issue_arbiter: two-requester issue arbiter in front of an OVI vector unit.
// Requester A (scalar core) and B (test sequencer) share one issue port. A tag FIFO
// remembers who issued each instruction so in-order completions are routed back.
// Build option: define OVI_ARB_FIXED_PRIO_EN for fixed priority (A over B);
// the default build uses round-robin.
//
// CORE_ISSUE layout (MSB..LSB): {instr, opnd, vl, sew, valid}.
// CORE_COMPLETED layout: bit 0 is valid; upper bits carry status not used here.

`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_DATA_WIDTH
`define OVI_DATA_WIDTH 64
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 14
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif
`ifndef OVI_COMPLETED_WIDTH
`define OVI_COMPLETED_WIDTH 8
`endif
`ifndef OVI_ISSUE_WIDTH
`define OVI_ISSUE_WIDTH (`OVI_INSTR_WIDTH + `OVI_DATA_WIDTH + `OVI_VL_WIDTH + `OVI_SEW_WIDTH + 1)
`endif

module ovi_issue_arbiter #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            A_VALID,
  input  logic                            B_VALID,
  input  logic [`OVI_INSTR_WIDTH-1:0]     A_INSTR,
  input  logic [`OVI_INSTR_WIDTH-1:0]     B_INSTR,
  input  logic [`OVI_VL_WIDTH-1:0]        A_VL,
  input  logic [`OVI_VL_WIDTH-1:0]        B_VL,
  input  logic [`OVI_SEW_WIDTH-1:0]       A_SEW,
  input  logic [`OVI_SEW_WIDTH-1:0]       B_SEW,
  output logic                            A_READY,
  output logic                            B_READY,
  input  logic                            HALT,
  output logic [`OVI_ISSUE_WIDTH-1:0]     CORE_ISSUE,
  input  logic [`OVI_COMPLETED_WIDTH-1:0] CORE_COMPLETED,
  output logic                            A_DONE,
  output logic                            B_DONE,
  output logic                            IDLE,
  output logic                            ERR
);

  localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUT + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUT);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [MAX_OUT-1:0]   tags_q;
  logic                 err_q;

  logic comp_valid;
  logic pop;
  logic room;
  logic grant;
  logic pick_b;
  logic grant_a;
  logic grant_b;
  logic pop_tag;
  logic unused_completed;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign comp_valid       = CORE_COMPLETED[0];
  assign unused_completed = ^CORE_COMPLETED[`OVI_COMPLETED_WIDTH-1:1];

  // A completion with nothing outstanding is an underflow and is dropped.
  assign pop     = comp_valid && (count_q != '0);
  assign pop_tag = tags_q[rd_ptr_q];

  // A completion in this cycle frees a slot, so a full FIFO can still issue.
  assign room  = (count_q < CntMax) || pop;
  assign grant = (state_q == StRun) && !HALT && room && (A_VALID || B_VALID);

`ifdef OVI_ARB_FIXED_PRIO_EN
  assign pick_b = !A_VALID;
`else
  logic prefer_b_q;

  assign pick_b = B_VALID && (!A_VALID || prefer_b_q);

  // Round-robin pointer: after a grant, the other requester is preferred.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prefer_b_q <= 1'b0;
    end else if (grant) begin
      prefer_b_q <= !pick_b;
    end
  end
`endif

  assign grant_a = grant && !pick_b;
  assign grant_b = grant && pick_b;
  assign A_READY = grant_a;
  assign B_READY = grant_b;
  assign A_DONE  = pop && !pop_tag;
  assign B_DONE  = pop && pop_tag;
  assign IDLE    = (state_q == StHalted) && (count_q == '0);
  assign ERR     = err_q;

  // Issue payload: the granted requester's fields, all zero when idle.
  always_comb begin
    CORE_ISSUE = '0;
    if (grant_a) begin
      CORE_ISSUE = {A_INSTR, {`OVI_DATA_WIDTH{1'b0}}, A_VL, A_SEW, 1'b1};
    end else if (grant_b) begin
      CORE_ISSUE = {B_INSTR, {`OVI_DATA_WIDTH{1'b0}}, B_VL, B_SEW, 1'b1};
    end
  end

  // Next-state for the run/drain/halt FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (HALT) state_d = StDrain;
      end
      StDrain: begin
        if (!HALT) begin
          state_d = StRun;
        end else if (count_q == '0) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!HALT) state_d = StRun;
      end
      default: state_d = StHalted;
    endcase
  end

  // Outstanding count: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (grant && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!grant && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State, counter, pointers and sticky error flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= StHalted;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (grant) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      if (comp_valid && (count_q == '0)) err_q <= 1'b1;
    end
  end

  // Tag storage: source ID of each issued instruction (0=A, 1=B).
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tags_q <= '0;
    end else if (grant) begin
      tags_q[wr_ptr_q] <= pick_b;
    end
  end

endmodule

// File: tb/tb_ovi_issue_arbiter.sv
// Directed bench for ovi_issue_arbiter (MAX_OUT=4). Define OVI_ARB_FIXED_PRIO_EN
// for both RTL and bench to exercise the fixed-priority build.

`ifndef OVI_INSTR_WIDTH
`define OVI_INSTR_WIDTH 32
`endif
`ifndef OVI_DATA_WIDTH
`define OVI_DATA_WIDTH 64
`endif
`ifndef OVI_VL_WIDTH
`define OVI_VL_WIDTH 14
`endif
`ifndef OVI_SEW_WIDTH
`define OVI_SEW_WIDTH 3
`endif
`ifndef OVI_COMPLETED_WIDTH
`define OVI_COMPLETED_WIDTH 8
`endif
`ifndef OVI_ISSUE_WIDTH
`define OVI_ISSUE_WIDTH (`OVI_INSTR_WIDTH + `OVI_DATA_WIDTH + `OVI_VL_WIDTH + `OVI_SEW_WIDTH + 1)
`endif

module tb_ovi_issue_arbiter;

  logic                            CLK = 1'b0;
  logic                            RSTN;
  logic                            A_VALID, B_VALID, HALT;
  logic [`OVI_INSTR_WIDTH-1:0]     A_INSTR, B_INSTR;
  logic [`OVI_VL_WIDTH-1:0]        A_VL, B_VL;
  logic [`OVI_SEW_WIDTH-1:0]       A_SEW, B_SEW;
  logic                            A_READY, B_READY;
  logic [`OVI_ISSUE_WIDTH-1:0]     CORE_ISSUE;
  logic [`OVI_COMPLETED_WIDTH-1:0] CORE_COMPLETED;
  logic                            A_DONE, B_DONE, IDLE, ERR;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ovi_issue_arbiter #(.MAX_OUT(4)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .A_VALID(A_VALID), .B_VALID(B_VALID),
    .A_INSTR(A_INSTR), .B_INSTR(B_INSTR),
    .A_VL(A_VL), .B_VL(B_VL), .A_SEW(A_SEW), .B_SEW(B_SEW),
    .A_READY(A_READY), .B_READY(B_READY),
    .HALT(HALT), .CORE_ISSUE(CORE_ISSUE), .CORE_COMPLETED(CORE_COMPLETED),
    .A_DONE(A_DONE), .B_DONE(B_DONE), .IDLE(IDLE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_comp(input logic v);
    CORE_COMPLETED    = '0;
    CORE_COMPLETED[0] = v;
  endtask

  task automatic test_reset;
    RSTN = 1'b1; HALT = 1'b0; A_VALID = 1'b1; B_VALID = 1'b1; set_comp(1'b1);
    #2 RSTN = 1'b0;
    #1;
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL reset_a_ready got %b want 0", A_READY); end
    n_vec++; if (B_READY !== 1'b0) begin n_err++; $display("FAIL reset_b_ready got %b want 0", B_READY); end
    n_vec++; if (CORE_ISSUE !== '0) begin n_err++; $display("FAIL reset_issue got %h want 0", CORE_ISSUE); end
    n_vec++; if ({A_DONE, B_DONE} !== 2'b00) begin n_err++; $display("FAIL reset_done got %b want 00", {A_DONE, B_DONE}); end
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", ERR); end
    n_vec++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", IDLE); end
    tick; tick;
    RSTN = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0; set_comp(1'b0);
    #1;
    n_vec++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL release_idle got %b want 1", IDLE); end
    tick;
    // First edge after release moves HALTED->RUN.
    n_vec++; if (IDLE !== 1'b0) begin n_err++; $display("FAIL run_idle got %b want 0", IDLE); end
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL run_err got %b want 0", ERR); end
  endtask

  task automatic test_round_robin;
    logic [5:0] e_ar, e_br, e_ad, e_bd;
    logic [`OVI_ISSUE_WIDTH-1:0] e_iss;
`ifdef OVI_ARB_FIXED_PRIO_EN
    e_ar = 6'b111111; e_br = 6'b000000; e_ad = 6'b111110; e_bd = 6'b000000;
`else
    e_ar = 6'b010101; e_br = 6'b101010; e_ad = 6'b101010; e_bd = 6'b010100;
`endif
    A_INSTR = 32'hA000_0001; A_VL = 14'd17; A_SEW = 3'd2;
    B_INSTR = 32'hB000_0002; B_VL = 14'd33; B_SEW = 3'd3;
    for (int i = 0; i < 6; i++) begin
      A_VALID = 1'b1; B_VALID = 1'b1; set_comp(i > 0);
      #1;
      e_iss = e_ar[i] ? {A_INSTR, {`OVI_DATA_WIDTH{1'b0}}, A_VL, A_SEW, 1'b1}
                      : {B_INSTR, {`OVI_DATA_WIDTH{1'b0}}, B_VL, B_SEW, 1'b1};
      n_vec++; if (A_READY !== e_ar[i]) begin n_err++; $display("FAIL rr_a_ready[%0d] got %b want %b", i, A_READY, e_ar[i]); end
      n_vec++; if (B_READY !== e_br[i]) begin n_err++; $display("FAIL rr_b_ready[%0d] got %b want %b", i, B_READY, e_br[i]); end
      n_vec++; if (A_DONE !== e_ad[i]) begin n_err++; $display("FAIL rr_a_done[%0d] got %b want %b", i, A_DONE, e_ad[i]); end
      n_vec++; if (B_DONE !== e_bd[i]) begin n_err++; $display("FAIL rr_b_done[%0d] got %b want %b", i, B_DONE, e_bd[i]); end
      n_vec++; if (CORE_ISSUE !== e_iss) begin n_err++; $display("FAIL rr_issue[%0d] got %h want %h", i, CORE_ISSUE, e_iss); end
      tick;
    end
    A_VALID = 1'b0; B_VALID = 1'b0; set_comp(1'b1);
    #1;
`ifdef OVI_ARB_FIXED_PRIO_EN
    n_vec++; if ({A_DONE, B_DONE} !== 2'b10) begin n_err++; $display("FAIL rr_last_done got %b want 10", {A_DONE, B_DONE}); end
`else
    n_vec++; if ({A_DONE, B_DONE} !== 2'b01) begin n_err++; $display("FAIL rr_last_done got %b want 01", {A_DONE, B_DONE}); end
`endif
    n_vec++; if (CORE_ISSUE[0] !== 1'b0) begin n_err++; $display("FAIL rr_idle_valid got %b want 0", CORE_ISSUE[0]); end
    tick;
    set_comp(1'b0);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      A_VALID = 1'b1;
      #1;
      n_vec++; if (A_READY !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b want 1", i, A_READY); end
      tick;
    end
    #1;
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", A_READY); end
    n_vec++; if (CORE_ISSUE[0] !== 1'b0) begin n_err++; $display("FAIL full_valid got %b want 0", CORE_ISSUE[0]); end
    tick;
    set_comp(1'b1);
    #1;
    n_vec++; if (A_DONE !== 1'b1) begin n_err++; $display("FAIL fill_done got %b want 1", A_DONE); end
    n_vec++; if (A_READY !== 1'b1) begin n_err++; $display("FAIL fill_reissue got %b want 1", A_READY); end
    tick;
    set_comp(1'b0);
    #1;
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL refull_ready got %b want 0", A_READY); end
    tick;
  endtask

  task automatic test_full_swap;
    // Four A tags outstanding; complete one while B issues into the freed slot.
    A_VALID = 1'b0; B_VALID = 1'b1; set_comp(1'b1);
    #1;
    n_vec++; if (A_DONE !== 1'b1) begin n_err++; $display("FAIL swap_a_done got %b want 1", A_DONE); end
    n_vec++; if (B_READY !== 1'b1) begin n_err++; $display("FAIL swap_b_ready got %b want 1", B_READY); end
    tick;
    set_comp(1'b0);
    #1;
    n_vec++; if (B_READY !== 1'b0) begin n_err++; $display("FAIL swap_still_full got %b want 0", B_READY); end
    tick;
    B_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_comp(1'b1);
      #1;
      n_vec++; if (A_DONE !== (i < 3)) begin n_err++; $display("FAIL swap_drain_a[%0d] got %b want %b", i, A_DONE, i < 3); end
      n_vec++; if (B_DONE !== (i == 3)) begin n_err++; $display("FAIL swap_drain_b[%0d] got %b want %b", i, B_DONE, i == 3); end
      tick;
    end
    set_comp(1'b0);
    #1;
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL swap_err got %b want 0", ERR); end
    tick;
  endtask

  task automatic test_halt;
    for (int i = 0; i < 3; i++) begin
      A_VALID = 1'b1;
      #1;
      n_vec++; if (A_READY !== 1'b1) begin n_err++; $display("FAIL halt_pre_issue[%0d] got %b want 1", i, A_READY); end
      tick;
    end
    HALT = 1'b1;
    #1;
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL halt_same_cycle got %b want 0", A_READY); end
    tick;
    for (int i = 0; i < 3; i++) begin
      set_comp(1'b1);
      #1;
      n_vec++; if (A_DONE !== 1'b1) begin n_err++; $display("FAIL drain_done[%0d] got %b want 1", i, A_DONE); end
      n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL drain_ready[%0d] got %b want 0", i, A_READY); end
      n_vec++; if (IDLE !== 1'b0) begin n_err++; $display("FAIL drain_idle[%0d] got %b want 0", i, IDLE); end
      tick;
    end
    set_comp(1'b0);
    // Still DRAIN with zero outstanding; HALTED is entered on the next edge.
    #1;
    n_vec++; if (IDLE !== 1'b0) begin n_err++; $display("FAIL drain_empty_idle got %b want 0", IDLE); end
    tick;
    n_vec++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL halted_idle got %b want 1", IDLE); end
    HALT = 1'b0;
    #1;
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL unhalt_same_cycle got %b want 0", A_READY); end
    tick;
    n_vec++; if (A_READY !== 1'b1) begin n_err++; $display("FAIL resume_ready got %b want 1", A_READY); end
    n_vec++; if (IDLE !== 1'b0) begin n_err++; $display("FAIL resume_idle got %b want 0", IDLE); end
    tick;
    A_VALID = 1'b0; set_comp(1'b1);
    #1;
    n_vec++; if (A_DONE !== 1'b1) begin n_err++; $display("FAIL resume_done got %b want 1", A_DONE); end
    tick;
    set_comp(1'b0);
  endtask

  task automatic test_underflow;
    set_comp(1'b1);
    #1;
    n_vec++; if ({A_DONE, B_DONE} !== 2'b00) begin n_err++; $display("FAIL uf_done got %b want 00", {A_DONE, B_DONE}); end
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL uf_err_pre got %b want 0", ERR); end
    tick;
    set_comp(1'b0);
    #1;
    n_vec++; if (ERR !== 1'b1) begin n_err++; $display("FAIL uf_err_set got %b want 1", ERR); end
    tick; tick;
    A_VALID = 1'b1;
    #1;
    n_vec++; if (A_READY !== 1'b1) begin n_err++; $display("FAIL uf_issue got %b want 1", A_READY); end
    tick;
    A_VALID = 1'b0; set_comp(1'b1);
    #1;
    n_vec++; if (A_DONE !== 1'b1) begin n_err++; $display("FAIL uf_done_ok got %b want 1", A_DONE); end
    tick;
    set_comp(1'b0);
    #1;
    n_vec++; if (ERR !== 1'b1) begin n_err++; $display("FAIL uf_err_sticky got %b want 1", ERR); end
    tick;
  endtask

  task automatic test_reset_midflight;
    A_VALID = 1'b1;
    tick; tick;
    RSTN = 1'b0;
    #1;
    n_vec++; if (ERR !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got %b want 0", ERR); end
    n_vec++; if (A_READY !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b want 0", A_READY); end
    n_vec++; if (IDLE !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle got %b want 1", IDLE); end
    tick;
    RSTN = 1'b1; A_VALID = 1'b0;
    tick;
    set_comp(1'b1);
    #1;
    n_vec++; if ({A_DONE, B_DONE} !== 2'b00) begin n_err++; $display("FAIL mid_stale_done got %b want 00", {A_DONE, B_DONE}); end
    tick;
    set_comp(1'b0);
    #1;
    n_vec++; if (ERR !== 1'b1) begin n_err++; $display("FAIL mid_stale_err got %b want 1", ERR); end
    tick;
  endtask

  initial begin
    A_VALID = 1'b0; B_VALID = 1'b0; HALT = 1'b0; RSTN = 1'b1;
    A_INSTR = '0; B_INSTR = '0; A_VL = '0; B_VL = '0; A_SEW = '0; B_SEW = '0;
    CORE_COMPLETED = '0;
    test_reset;
    test_round_robin;
    test_fill;
    test_full_swap;
    test_halt;
    test_underflow;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
